// File: rtl/pov_led_pkg.sv
// Shared definitions for the POV LED sequencer: register map, CTRL/STATUS
// bit positions, reset values and the column FSM state encoding.
package pov_led_pkg;

    // Register word addresses
    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PERIOD   = 4'd1;
    localparam logic [3:0] ADDR_CLKDIV   = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_BUF_BASE = 4'd8;

    // CTRL / STATUS bit positions
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_OVR_BIT   = 1;
    localparam int STATUS_COL_LSB   = 4;

    // Reset values
    localparam logic [15:0] PERIOD_RST = 16'h03E7;
    localparam logic [7:0]  CLKDIV_RST = 8'h01;
    localparam logic [15:0] PERIOD_MAX = 16'hFFFF;

    // Column FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_WAIT     = 3'd5
    } state_e;

    // Period counter increment that sticks at full scale instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == PERIOD_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pov_led_shifter.sv
// Serial shifter for one LED column: holds the column word, times each sclk
// half-period (CLKDIV+1 clocks) and shifts MSB-first on request.
module pov_led_shifter
    import pov_led_pkg::*;
#(
    parameter int NUM_LEDS = 16
) (
    input  logic                csi_clk,
    input  logic                rsi_reset_n,
    input  logic                load_i,      // capture column word and divider
    input  logic [NUM_LEDS-1:0] data_i,
    input  logic [7:0]          clkdiv_i,
    input  logic                run_i,       // FSM is in SHIFT_LO or SHIFT_HI
    input  logic                shift_i,     // end of a SHIFT_HI phase
    output logic                half_done_o, // current half-period has elapsed
    output logic                last_bit_o,  // the bit on the line is the last one
    output logic                msb_o
);

    logic [NUM_LEDS-1:0] shreg_q;
    logic [7:0]          div_q;
    logic [7:0]          clkdiv_q;
    logic [5:0]          bit_q;

    assign half_done_o = run_i && (div_q == clkdiv_q);
    assign last_bit_o  = (bit_q == 6'(NUM_LEDS - 1));
    assign msb_o       = shreg_q[NUM_LEDS-1];

    // Shift register, half-period divider and bit counter
    // NOTE: every register in a clocked block is assigned with <= so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            shreg_q  <= '0;
            div_q    <= '0;
            clkdiv_q <= CLKDIV_RST;
            bit_q    <= '0;
        end else if (load_i) begin
            shreg_q  <= data_i;
            clkdiv_q <= clkdiv_i;
            div_q    <= '0;
            bit_q    <= '0;
        end else if (run_i) begin
            div_q <= half_done_o ? 8'd0 : div_q + 8'd1;
            if (shift_i) begin
                shreg_q <= shreg_q << 1;
                bit_q   <= bit_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/pov_led_sequencer.sv
// POV LED sequencer: Avalon-MM register file, column buffer and the column
// FSM driving an external LED shift-register chain.
// Optional build macro POV_SYNC_EN adds the sync_in frame-restart input.
module pov_led_sequencer
    import pov_led_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int NUM_COLS = 8
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
`ifdef POV_SYNC_EN
    input  logic        sync_in,
`endif
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        led_sclk,
    output logic        led_sdata,
    output logic        led_latch,
    output logic        frame_done
);

    localparam logic [2:0] COL_LAST = 3'(NUM_COLS - 1);

    state_e              state_q, state_d;
    logic [2:0]          col_q, col_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         period_q, period_act_q;
    logic [7:0]          clkdiv_q;
    logic                enable_q;
    logic                overrun_q;
    logic [NUM_LEDS-1:0] buf_q [NUM_COLS];
    logic [31:0]         readdata_q, rdata_d;

    logic       ovr_set, clr_ovr, wr_ctrl, buf_sel, sync_force;
    logic       shift, half_done, last_bit, msb;
    logic [3:0] buf_off;
    logic       unused_wdata;

    assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
    assign clr_ovr      = wr_ctrl && avs_writedata[CTRL_CLR_OVR_BIT];
    assign buf_off      = avs_address - ADDR_BUF_BASE;
    assign buf_sel      = (avs_address >= ADDR_BUF_BASE) && (buf_off < 4'(NUM_COLS));
    assign unused_wdata = ^avs_writedata;

    // Control and timing registers; new PERIOD/CLKDIV are only used from the next LOAD
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            enable_q <= 1'b0;
            period_q <= PERIOD_RST;
            clkdiv_q <= CLKDIV_RST;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_CTRL:   enable_q <= avs_writedata[CTRL_ENABLE_BIT];
                ADDR_PERIOD: period_q <= avs_writedata[15:0];
                ADDR_CLKDIV: clkdiv_q <= avs_writedata[7:0];
                default:     ;
            endcase
        end
    end

    // Column buffer
    // NOTE: this small register array is explicitly cleared on reset; a large
    // RAM-style buffer would normally be left unreset so it maps onto block RAM.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            for (int i = 0; i < NUM_COLS; i++) buf_q[i] <= '0;
        end else if (avs_write && buf_sel) begin
            buf_q[buf_off[2:0]] <= avs_writedata[NUM_LEDS-1:0];
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n)  overrun_q <= 1'b0;
        else if (ovr_set)  overrun_q <= 1'b1;
        else if (clr_ovr)  overrun_q <= 1'b0;
    end

    // Read data mux; unused bits and unmapped addresses return zero
    // NOTE: the default assignment first guarantees every path writes rdata_d,
    // so no latch is inferred for the unlisted cases.
    always_comb begin
        rdata_d = '0;
        case (avs_address)
            ADDR_CTRL:   rdata_d[CTRL_ENABLE_BIT] = enable_q;
            ADDR_PERIOD: rdata_d[15:0] = period_q;
            ADDR_CLKDIV: rdata_d[7:0]  = clkdiv_q;
            ADDR_STATUS: begin
                rdata_d[STATUS_BUSY_BIT]        = (state_q != ST_IDLE);
                rdata_d[STATUS_OVR_BIT]         = overrun_q;
                rdata_d[STATUS_COL_LSB +: 3]    = col_q;
            end
            default: if (buf_sel) rdata_d[NUM_LEDS-1:0] = buf_q[buf_off[2:0]];
        endcase
    end

    // Registered read data, one cycle after avs_read
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n)  readdata_q <= '0;
        else if (avs_read) readdata_q <= rdata_d;
    end

    assign avs_readdata = readdata_q;

`ifdef POV_SYNC_EN
    logic [2:0] sync_q;

    // Double-flop synchroniser plus one stage for rising-edge detection
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) sync_q <= '0;
        else              sync_q <= {sync_q[1:0], sync_in};
    end

    assign sync_force = sync_q[1] && !sync_q[2] && (state_q != ST_IDLE);
`else
    assign sync_force = 1'b0;
`endif

    // FSM next state, column index, period counter and overrun detection
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ovr_set = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d = ST_LOAD;
                    col_d   = '0;
                end
            end
            ST_LOAD:     state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (half_done) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (half_done) begin
                    shift   = 1'b1;
                    state_d = last_bit ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                state_d = ST_WAIT;
                ovr_set = (cnt_q >= period_act_q);
            end
            ST_WAIT: begin
                if (cnt_q >= period_act_q) begin
                    if (enable_q) begin
                        state_d = ST_LOAD;
                        col_d   = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (sync_force) begin
            state_d = ST_LOAD;
            col_d   = '0;
        end
        cnt_d = (state_d == ST_LOAD) ? 16'd0 : sat_inc16(cnt_q);
    end

    // FSM state, column, counter and the period in force for this column
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            cnt_q        <= '0;
            period_act_q <= PERIOD_RST;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_LOAD) period_act_q <= period_q;
        end
    end

    pov_led_shifter #(
        .NUM_LEDS (NUM_LEDS)
    ) u_shifter (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .load_i      (state_q == ST_LOAD),
        .data_i      (buf_q[col_q]),
        .clkdiv_i    (clkdiv_q),
        .run_i       ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI)),
        .shift_i     (shift),
        .half_done_o (half_done),
        .last_bit_o  (last_bit),
        .msb_o       (msb)
    );

    assign led_sclk   = (state_q == ST_SHIFT_HI);
    assign led_sdata  = ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI)) && msb;
    assign led_latch  = (state_q == ST_LATCH);
    assign frame_done = (state_q == ST_LATCH) && (col_q == COL_LAST);

endmodule

// File: tb/tb_pov_led_sequencer.sv
// Directed testbench for pov_led_sequencer (NUM_LEDS=16, NUM_COLS=8).
// Build with POV_SYNC_EN defined to include the sync_in restart case.
module tb_pov_led_sequencer;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n;
    logic [3:0]  avs_address;
    logic        avs_write, avs_read;
    logic [31:0] avs_writedata, avs_readdata;
    logic        led_sclk, led_sdata, led_latch, frame_done;
`ifdef POV_SYNC_EN
    logic        sync_in;
`endif

    always #5 csi_clk = ~csi_clk;

    pov_led_sequencer #(.NUM_LEDS(16), .NUM_COLS(8)) dut (
        .csi_clk       (csi_clk),
        .rsi_reset_n   (rsi_reset_n),
`ifdef POV_SYNC_EN
        .sync_in       (sync_in),
`endif
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .led_sclk      (led_sclk),
        .led_sdata     (led_sdata),
        .led_latch     (led_latch),
        .frame_done    (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Line monitor: reconstructs each shifted column and times latch/frame pulses
    int          cyc = 0, latch_cnt = 0, fd_cnt = 0, rises = 0, rises_at_latch = 0;
    int          lat_len = 0, lat_len_max = 0, fd_len = 0, fd_len_max = 0;
    int          last_latch_cyc = 0, latch_gap = 0, last_fd_cyc = 0, fd_gap = 0;
    logic [31:0] rx = '0;
    logic        prev_sclk = 1'b0;
    logic [15:0] words [256];

    always @(negedge csi_clk) begin
        cyc <= cyc + 1;
        if (!rsi_reset_n) begin
            rises     <= 0;
            rx        <= '0;
            prev_sclk <= 1'b0;
        end else begin
            prev_sclk <= led_sclk;
            if (led_sclk && !prev_sclk) begin
                rx    <= {rx[30:0], led_sdata};
                rises <= rises + 1;
            end
            if (led_latch) begin
                if (lat_len == 0) begin
                    if (latch_cnt < 256) words[latch_cnt] <= rx[15:0];
                    rises_at_latch <= rises;
                    rises          <= 0;
                    rx             <= '0;
                    latch_gap      <= cyc - last_latch_cyc;
                    last_latch_cyc <= cyc;
                    latch_cnt      <= latch_cnt + 1;
                end
                lat_len <= lat_len + 1;
                if (lat_len + 1 > lat_len_max) lat_len_max <= lat_len + 1;
            end else begin
                lat_len <= 0;
            end
            if (frame_done) begin
                if (fd_len == 0) begin
                    fd_gap      <= cyc - last_fd_cyc;
                    last_fd_cyc <= cyc;
                    fd_cnt      <= fd_cnt + 1;
                end
                fd_len <= fd_len + 1;
                if (fd_len + 1 > fd_len_max) fd_len_max <= fd_len + 1;
            end else begin
                fd_len <= 0;
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge csi_clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge csi_clk);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge csi_clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge csi_clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wait_latches(input int n, input int budget, input string tag);
        int k = 0;
        while (latch_cnt < n && k < budget) begin
            @(posedge csi_clk);
            k++;
        end
        check(tag, 32'(latch_cnt >= n), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (fd_cnt < n && k < budget) begin
            @(posedge csi_clk);
            k++;
        end
        check(tag, 32'(fd_cnt >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic [31:0] s;
        int k = 0;
        s = 32'd1;
        while (s[0] && k < budget) begin
            bus_read(4'd3, s);
            k++;
        end
        check(tag, {31'd0, s[0]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [15:0] col_data [8];
    logic [31:0] rd;
    int          base, n0, k, sync_cyc;

    initial begin
        col_data = '{16'hA5C3, 16'h8001, 16'h7FFE, 16'h1234,
                     16'hF00F, 16'h0F0F, 16'hFFFF, 16'h0000};
        avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
`ifdef POV_SYNC_EN
        sync_in = 1'b0;
`endif
        rsi_reset_n = 1'b0;
        #1;
        check("rst_sclk",  {31'd0, led_sclk},   32'd0);
        check("rst_sdata", {31'd0, led_sdata},  32'd0);
        check("rst_latch", {31'd0, led_latch},  32'd0);
        check("rst_fdone", {31'd0, frame_done}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        repeat (3) @(negedge csi_clk);
        rsi_reset_n = 1'b1;

        // Reset values and register map
        bus_read(4'd1, rd);  check("rst_period", rd, 32'h3E7);
        bus_read(4'd2, rd);  check("rst_clkdiv", rd, 32'h1);
        bus_read(4'd0, rd);  check("rst_ctrl",   rd, 32'h0);
        bus_read(4'd3, rd);  check("rst_status", rd, 32'h0);
        bus_read(4'd8, rd);  check("rst_buf0",   rd, 32'h0);
        for (int i = 0; i < 8; i++) bus_write(4'(8 + i), {16'hDEAD, col_data[i]});
        bus_read(4'd11, rd); check("buf3_rb", rd, 32'h1234);
        bus_write(4'd3, 32'hFFFF_FFFF);
        bus_read(4'd3, rd);  check("status_ro", rd, 32'h0);
        bus_write(4'd5, 32'hFFFF_FFFF);
        bus_read(4'd5, rd);  check("unmapped", rd, 32'h0);

        // One column MSB-first, then free-running frames at PERIOD=99, CLKDIV=0
        bus_write(4'd1, 32'd99);
        bus_write(4'd2, 32'd0);
        bus_write(4'd0, 32'd1);
        bus_read(4'd0, rd);  check("ctrl_rb", rd, 32'h1);
        wait_latches(1, 200, "first_latch_seen");
        check("first_bits",  {16'd0, words[0]}, 32'h0000A5C3);
        check("first_rises", rises_at_latch, 32'd16);
        check("no_early_fd", fd_cnt, 32'd0);
        wait_frames(2, 2000, "frames_seen");
        check("latch_gap",   latch_gap, 32'd100);
        check("frame_gap",   fd_gap, 32'd800);
        check("latch_width", lat_len_max, 32'd1);
        check("fd_width",    fd_len_max, 32'd1);
        check("col1_bits",   {16'd0, words[1]}, {16'd0, col_data[1]});
        check("col7_bits",   {16'd0, words[7]}, {16'd0, col_data[7]});
        check("wrap_bits",   {16'd0, words[8]}, {16'd0, col_data[0]});
        bus_read(4'd3, rd);
        check("no_ovr",  {31'd0, rd[1]}, 32'd0);
        check("busy_on", {31'd0, rd[0]}, 32'd1);

        // Overrun: shifting takes 128 clocks against PERIOD=10
        bus_write(4'd1, 32'd10);
        bus_write(4'd2, 32'd3);
        n0 = latch_cnt;
        wait_latches(n0 + 3, 600, "ovr_latches_seen");
        check("ovr_gap",  latch_gap, 32'd131);
        check("ovr_bits", {16'd0, words[n0 + 2]}, {16'd0, col_data[(n0 + 2) % 8]});
        bus_read(4'd3, rd);
        check("ovr_set", {31'd0, rd[1]}, 32'd1);

        // Clear written in the latch cycle collides with a new overrun
        k = 0;
        @(negedge csi_clk);
        while (!led_latch && k < 400) begin
            @(negedge csi_clk);
            k++;
        end
        check("latch_found", {31'd0, led_latch}, 32'd1);
        avs_address = 4'd0; avs_writedata = 32'h3; avs_write = 1'b1;
        @(negedge csi_clk);
        avs_write = 1'b0;
        bus_read(4'd3, rd);
        check("ovr_set_wins", {31'd0, rd[1]}, 32'd1);
        repeat (5) @(negedge csi_clk);
        bus_write(4'd0, 32'h3);
        bus_read(4'd3, rd);
        check("ovr_cleared", {31'd0, rd[1]}, 32'd0);

        // Disable during column 3 shift: column 3 still latches, then IDLE
        bus_write(4'd0, 32'h0);
        wait_idle(200, "went_idle");
        bus_write(4'd0, 32'h2);
        bus_write(4'd1, 32'd99);
        bus_write(4'd2, 32'd0);
        base = latch_cnt;
        bus_write(4'd0, 32'h1);
        wait_latches(base + 3, 400, "cols012_seen");
        repeat (78) @(posedge csi_clk);
        bus_read(4'd3, rd);  check("col3_status", rd, 32'h31);
        bus_write(4'd0, 32'h0);
        wait_latches(base + 4, 200, "col3_latch_seen");
        check("col3_bits", {16'd0, words[base + 3]}, {16'd0, col_data[3]});
        bus_read(4'd3, rd);  check("wait_busy", rd, 32'h31);
        repeat (120) @(posedge csi_clk);
        bus_read(4'd3, rd);  check("idle_status", rd, 32'h30);
        check("no_more_latch", latch_cnt, base + 4);

        // Asynchronous reset mid-shift aborts without a latch pulse
        bus_write(4'd0, 32'h1);
        base = latch_cnt;
        repeat (14) @(posedge csi_clk);
        #2;
        rsi_reset_n = 1'b0;
        #1;
        check("arst_sclk",  {31'd0, led_sclk},  32'd0);
        check("arst_sdata", {31'd0, led_sdata}, 32'd0);
        check("arst_latch", {31'd0, led_latch}, 32'd0);
        repeat (2) @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        repeat (60) @(posedge csi_clk);
        check("arst_no_latch", latch_cnt, base);
        bus_read(4'd0, rd);  check("arst_ctrl",   rd, 32'h0);
        bus_read(4'd1, rd);  check("arst_period", rd, 32'h3E7);
        bus_read(4'd8, rd);  check("arst_buf0",   rd, 32'h0);

`ifdef POV_SYNC_EN
        // Sync edge during column 5 restarts the frame at column 0
        for (int i = 0; i < 8; i++) bus_write(4'(8 + i), {16'd0, col_data[i]});
        bus_write(4'd1, 32'd99);
        bus_write(4'd2, 32'd0);
        base = latch_cnt;
        bus_write(4'd0, 32'h1);
        wait_latches(base + 5, 700, "cols0to4_seen");
        repeat (75) @(posedge csi_clk);
        @(negedge csi_clk);
        sync_in  = 1'b1;
        sync_cyc = cyc;
        repeat (3) @(negedge csi_clk);
        sync_in  = 1'b0;
        wait_latches(base + 6, 100, "sync_latch_seen");
        check("sync_col0_bits", {16'd0, words[base + 5]}, {16'd0, col_data[0]});
        check("sync_latency", 32'((last_latch_cyc - sync_cyc) <= 39), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pov_led_sequencer.md
POV_LED_SEQUENCER -- requirements
Module: pov_led_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 16, LEDs per column (bits shifted per column), range 1..32.
REQ-002 SHALL have parameter NUM_COLS, default 8, columns per frame, range 1..8.
REQ-003 SHALL have port csi_clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rsi_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port avs_address  in  4  register word address.
REQ-006 SHALL have ports avs_write, avs_read  in  1  Avalon-MM strobes; no waitrequest.
REQ-007 SHALL have port avs_writedata  in  32  write data.
REQ-008 SHALL have port avs_readdata  out  32  read data, registered.
REQ-009 SHALL have ports led_sclk, led_sdata, led_latch  out  1  serial clock, data and latch to the external LED shift-register chain.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse after the last column of a frame latches.

Function
REQ-011 Register map SHALL be: 0 CTRL (bit0 enable, bit1 clear_ovr, self-clearing); 1 PERIOD[15:0] (column period minus 1, in clocks); 2 CLKDIV[7:0] (sclk half-period minus 1); 3 STATUS (read-only: bit0 busy, bit1 overrun sticky, bits[6:4] current column); 8..8+NUM_COLS-1 column buffer words [NUM_LEDS-1:0].
REQ-012 Reads SHALL return data on avs_readdata one cycle after avs_read; unmapped/unused bits read 0; writes to read-only/unmapped addresses SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, WAIT.
REQ-014 IDLE->LOAD when enable=1; column index reset to 0 on leaving IDLE.
REQ-015 LOAD: copy buffer[col] into shift register and start period counter at 0 in the same cycle; ->SHIFT_LO next cycle.
REQ-016 SHIFT_LO: led_sclk=0, led_sdata=current MSB, held CLKDIV+1 clocks; ->SHIFT_HI.
REQ-017 SHIFT_HI: led_sclk=1, held CLKDIV+1 clocks; then shift left; ->SHIFT_LO if bits remain, else ->LATCH.
REQ-018 LATCH: led_latch=1 for exactly one clock; led_sclk=0; frame_done=1 in the same cycle if col=NUM_COLS-1; ->WAIT.
REQ-019 WAIT: remain until period counter reaches PERIOD; then advance col (wrap NUM_COLS-1->0) and ->LOAD, or ->IDLE if enable=0.
REQ-020 Overrun: if counter has already reached PERIOD on entering WAIT, SHALL set overrun and go to LOAD (or IDLE) next cycle.
REQ-021 Period counter SHALL saturate at 0xFFFF, never wrap.
REQ-022 PERIOD and CLKDIV writes SHALL take effect at the next LOAD; buffer writes SHALL affect a column only at its next LOAD.
REQ-023 enable cleared mid-column SHALL let the current column complete through LATCH and WAIT before IDLE.
REQ-024 clear_ovr and simultaneous overrun set in the same cycle: set SHALL win.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 On rsi_reset_n low, immediately: FSM IDLE, led_sclk/led_sdata/led_latch/frame_done=0, avs_readdata=0, CTRL=0, PERIOD=0x03E7, CLKDIV=0x01, overrun=0, col=0, buffer all 0.
REQ-027 Reset mid-shift SHALL abort without a latch pulse.

Configuration
REQ-028 Macro POV_SYNC_EN SHALL, when defined, add input sync_in (1 bit, asynchronous, double-flop synchronised); a synchronised rising edge while busy SHALL force col=0 and state LOAD next cycle, aborting any shift without latch.
REQ-029 Without POV_SYNC_EN, no sync_in port exists and frames run free.

Structure
REQ-030 Register addresses, CTRL/STATUS bit positions, reset values and the FSM state enum SHALL live in shared package pov_led_pkg.
REQ-031 Serial shifter (SHIFT_LO/SHIFT_HI bit timing, shift register) MAY be sub-module pov_led_shifter; FSM and register file stay in the top.

Verification
REQ-032 Reset, read PERIOD and CLKDIV -> 0x3E7, 0x01; all outputs 0.
REQ-033 NUM_LEDS=16, CLKDIV=0, buf[8]=0xA5C3, enable -> sdata sampled on 16 sclk rises = 1010010111000011, one latch pulse after bit 16.
REQ-034 PERIOD=99, CLKDIV=0, NUM_COLS=8 -> LOAD every 100 clocks, frame_done every 800 clocks, overrun=0.
REQ-035 PERIOD=10, CLKDIV=3, NUM_LEDS=16 -> overrun=1, columns back-to-back; write CTRL=0x3 while overrun persists -> overrun stays 1.
REQ-036 Clear enable during column 3 shift -> column 3 latches, WAIT completes, then IDLE, busy=0.
REQ-037 With POV_SYNC_EN, pulse sync_in during column 5 -> no latch for column 5, next LOAD uses col 0 within 4 clocks of the edge.
